// File: rtl/pipe_maindec.sv
// Main decoder for the pipelined RV32 core.
// Decodes the opcode in Decode, flags illegal opcodes with all-zero controls,
// and registers the Execute-stage control bundle with stall/flush handling.
// Ports:
//   clk, reset_n                  clock and async active-low reset
//   OpD, ValidD                   Decode-stage opcode and valid qualifier
//   StallE, FlushE                Execute register hold / bubble insertion
//   ImmSrcD, IllegalD             combinational Decode-stage outputs
//   RegWriteE ... JumpRegE        registered Execute-stage controls
//   ValidE, IllegalE              Execute slot status
//   IllegalCnt                    saturating count of illegal instrs entering Execute
module pipe_maindec #(
  parameter bit          EN_JALR  = 1'b1,
  parameter bit          EN_AUIPC = 1'b1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       OpD,
  input  logic             ValidD,
  input  logic             StallE,
  input  logic             FlushE,
  output logic [2:0]       ImmSrcD,
  output logic             IllegalD,
  output logic             RegWriteE,
  output logic [1:0]       ALUSrcAE,
  output logic             ALUSrcBE,
  output logic             MemWriteE,
  output logic [1:0]       ResultSrcE,
  output logic             BranchE,
  output logic [1:0]       ALUOpE,
  output logic             JumpE,
  output logic             JumpRegE,
  output logic             ValidE,
  output logic             IllegalE,
  output logic [CNT_W-1:0] IllegalCnt
);

  // Controls carried into Execute (ImmSrc is consumed in Decode only)
  typedef struct packed {
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic       alu_src_b;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic [1:0] alu_op;
    logic       jump;
    logic       jump_reg;
  } ctrl_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ctrl_t            dec_ctrl;
  logic [2:0]       dec_imm;
  logic             known_op;
  ctrl_t            ctrl_d;
  ctrl_t            ctrl_e;
  logic             valid_e;
  logic             illegal_e;
  logic [CNT_W-1:0] illegal_cnt;

  // Opcode decode; unknown or disabled opcodes leave everything at zero
  always_comb begin
    dec_ctrl = '0;
    dec_imm  = 3'b000;
    known_op = 1'b1;
    case (OpD)
      7'b0000011: dec_ctrl = '{1'b1, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0};
      7'b0100011: begin
        dec_ctrl = '{1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0};
        dec_imm  = 3'b001;
      end
      7'b0110011: dec_ctrl = '{1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0};
      7'b1100011: begin
        dec_ctrl = '{1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 1'b0};
        dec_imm  = 3'b010;
      end
      7'b0010011: dec_ctrl = '{1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0};
      7'b1101111: begin
        dec_ctrl = '{1'b1, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00, 1'b1, 1'b0};
        dec_imm  = 3'b011;
      end
      7'b0110111: begin
        dec_ctrl = '{1'b1, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0};
        dec_imm  = 3'b100;
      end
      7'b1100111: begin
        if (EN_JALR) dec_ctrl = '{1'b1, 2'b00, 1'b1, 1'b0, 2'b10, 1'b0, 2'b00, 1'b1, 1'b1};
        else         known_op = 1'b0;
      end
      7'b0010111: begin
        if (EN_AUIPC) begin
          dec_ctrl = '{1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0};
          dec_imm  = 3'b100;
        end else begin
          known_op = 1'b0;
        end
      end
      7'b0000000: known_op = 1'b1;  // all-zero opcode is a bubble, not illegal
      default:    known_op = 1'b0;
    endcase
  end

  // Bubbles and illegal opcodes both present all-zero controls
  always_comb begin
    IllegalD = ValidD & ~known_op;
    ctrl_d   = '0;
    ImmSrcD  = 3'b000;
    if (ValidD && known_op) begin
      ctrl_d  = dec_ctrl;
      ImmSrcD = dec_imm;
    end
  end

  // Execute register: reset > flush > stall > load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_e      <= '0;
      valid_e     <= 1'b0;
      illegal_e   <= 1'b0;
      illegal_cnt <= '0;
    end else if (FlushE) begin
      ctrl_e    <= '0;
      valid_e   <= 1'b0;
      illegal_e <= 1'b0;
    end else if (!StallE) begin
      ctrl_e    <= ctrl_d;
      valid_e   <= ValidD & ~IllegalD;
      illegal_e <= IllegalD;
      // Counting only on the load path keeps stalled cycles from re-counting
      if (IllegalD && (illegal_cnt != CNT_MAX)) begin
        illegal_cnt <= illegal_cnt + CNT_W'(1);
      end
    end
  end

  assign RegWriteE  = ctrl_e.reg_write;
  assign ALUSrcAE   = ctrl_e.alu_src_a;
  assign ALUSrcBE   = ctrl_e.alu_src_b;
  assign MemWriteE  = ctrl_e.mem_write;
  assign ResultSrcE = ctrl_e.result_src;
  assign BranchE    = ctrl_e.branch;
  assign ALUOpE     = ctrl_e.alu_op;
  assign JumpE      = ctrl_e.jump;
  assign JumpRegE   = ctrl_e.jump_reg;
  assign ValidE     = valid_e;
  assign IllegalE   = illegal_e;
  assign IllegalCnt = illegal_cnt;

endmodule
